// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by host and device adapters, plus host FSM state encoding.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Optional feature macro: TLUL_HOST_TIMEOUT_EN (adds the DRAIN host state).
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;

    // log2 of the byte count of a full-word access
    localparam logic [TL_SZW-1:0] TL_SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic [TL_AUW-1:0]   a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic [TL_DUW-1:0]   d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        IDLE,
        AREQ,
        DWAIT
`ifdef TLUL_HOST_TIMEOUT_EN
        ,
        DRAIN
`endif
    } host_state_e;

    // A write is a PutFullData only when every byte lane is enabled.
    function automatic logic mask_is_full(input logic [TL_DBW-1:0] mask);
        return &mask;
    endfunction

endpackage

// File: rtl/tlul_adapter_host.sv
// Host-side TL-UL initiator: turns a req/gnt register master port into single-outstanding TL-UL accesses.
// Latency: grant in N -> a_valid in N+1; D accepted in M -> valid_o pulse in M+1 (new grant possible in M+1).
// Backpressure: a_valid and payload held until a_ready; req_i is only granted while idle.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/gnt_o            master request / one-cycle combinational grant
//   we_i, addr_i, wdata_i, be_i   request fields, captured on grant
//   valid_o, rdata_o, err_o       one-cycle response pulse; rdata_o/err_o hold until next response
//   tl_o / tl_i            TL-UL A channel + d_ready out, D channel + a_ready in
// Optional feature macro: TLUL_HOST_TIMEOUT_EN (D-channel watchdog + DRAIN state).
module tlul_adapter_host
    import tlul_pkg::*;
#(
    parameter logic [TL_AIW-1:0] SourceId      = '0,
    parameter int                DataW         = 32,
    parameter int                TimeoutCycles = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [DataW-1:0]   wdata_i,
    input  logic [DataW/8-1:0] be_i,
    output logic               valid_o,
    output logic [DataW-1:0]   rdata_o,
    output logic               err_o,
    output tl_h2d_t            tl_o,
    input  tl_d2h_t            tl_i
);

    host_state_e          r_state;
    host_state_e          w_state_nxt;
    tl_a_op_e             r_opcode;
    logic [TL_AW-1:0]     r_address;
    logic [TL_DBW-1:0]    r_mask;
    logic [TL_DW-1:0]     r_data;
    logic [DataW-1:0]     r_rdata;
    logic                 r_err;
    logic                 r_valid;

    logic                 w_gnt;
    logic                 w_a_valid;
    logic                 w_d_ready;
    logic                 w_resp;
    logic                 w_resp_err;
    tl_d_op_e             w_exp_dop;
    logic                 w_timeout;

    // Only a response arriving while waiting for one counts; D beats seen in
    // IDLE/AREQ are unsolicited and ignored (d_ready is low there anyway).
    assign w_resp     = (r_state == DWAIT) & tl_i.d_valid;
    assign w_exp_dop  = (r_opcode == Get) ? AccessAckData : AccessAck;
    assign w_resp_err = tl_i.d_error | (tl_i.d_source != SourceId) | (tl_i.d_opcode != w_exp_dop);

`ifdef TLUL_HOST_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] r_cnt;

    // A real response in the limit cycle takes priority over the timeout.
    assign w_timeout = (r_state == DWAIT) & ~tl_i.d_valid & (r_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == AREQ && tl_i.a_ready) begin
            r_cnt <= '0;
        end else if (r_state == DWAIT && !tl_i.d_valid) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, addr_i[1:0]};
`else
    assign w_timeout = 1'b0;

    logic w_unused;
    assign w_unused = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, addr_i[1:0],
                        w_timeout, TimeoutCycles[0]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_a_valid   = 1'b0;
        w_d_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt = req_i;
                if (req_i) w_state_nxt = AREQ;
            end
            AREQ: begin
                w_a_valid = 1'b1;
                if (tl_i.a_ready) w_state_nxt = DWAIT;
            end
            DWAIT: begin
                w_d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    w_state_nxt = IDLE;
                end
`ifdef TLUL_HOST_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = DRAIN;
                end
`endif
            end
`ifdef TLUL_HOST_TIMEOUT_EN
            // Swallow the late response so it cannot be mistaken for the next one.
            DRAIN: begin
                w_d_ready = 1'b1;
                if (tl_i.d_valid) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_opcode  <= PutFullData;
            r_address <= '0;
            r_mask    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (r_state == IDLE && req_i) begin
                r_opcode  <= we_i ? (mask_is_full(be_i) ? PutFullData : PutPartialData) : Get;
                r_address <= {addr_i[31:2], 2'b00};
                r_mask    <= we_i ? be_i : '1;
                r_data    <= we_i ? wdata_i : '0;
            end
            if (w_resp) begin
                r_valid <= 1'b1;
                r_err   <= w_resp_err;
                if (r_opcode == Get) r_rdata <= tl_i.d_data;
            end else if (w_timeout) begin
                r_valid <= 1'b1;
                r_err   <= 1'b1;
                r_rdata <= '1;
            end
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = w_a_valid;
        tl_o.a_opcode  = r_opcode;
        tl_o.a_param   = 3'b000;
        tl_o.a_size    = TL_SZ_WORD;
        tl_o.a_source  = SourceId;
        tl_o.a_address = r_address;
        tl_o.a_mask    = r_mask;
        tl_o.a_data    = r_data;
        tl_o.a_user    = '0;
        tl_o.d_ready   = w_d_ready;
    end

    assign gnt_o   = w_gnt;
    assign valid_o = r_valid;
    assign rdata_o = r_rdata;
    assign err_o   = r_err;

endmodule
